div_64by32_seq: RTL and testbench
=================================

# div_64by32_seq

Sequential unsigned divider, the inverse of the 32x32=64 combinational multiplier: it divides a 64-bit dividend by a 32-bit divisor to give a 32-bit quotient and a 32-bit remainder. It uses radix-2 restoring division, one quotient bit per cycle, behind a start/done handshake. It sits in the arithmetic datapath next to the multiplier, so a product from the multiplier can be divided back to recover an operand, and normalisation steps in the p-bit datapath can run without a combinational divider.

## Interface
- `WIDTH`, default 32: divisor, quotient and remainder width. The dividend is 2*WIDTH bits.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `dividend`  in  2*WIDTH  numerator; captured when start is accepted.
- `divisor`  in  WIDTH  denominator; captured when start is accepted.
- `busy`  out  1  high from the cycle after acceptance until done.
- `done`  out  1  single-cycle pulse when results become valid.
- `quotient`  out  WIDTH  result; held until the next accepted start.
- `remainder`  out  WIDTH  result; held until the next accepted start.
- `div_by_zero`  out  1  sticky flag for the last operation; divisor was 0.
- `overflow`  out  1  sticky flag for the last operation; the quotient does not fit in WIDTH bits.

## Operation
- States: IDLE, ITER, FIN.
- IDLE with start=1:
  - Capture the operands.
  - Clear div_by_zero and overflow.
  - If divisor==0: go to FIN, set div_by_zero=1, quotient=all-ones, remainder=dividend[WIDTH-1:0].
  - Else if dividend[2W-1:W] >= divisor: go to FIN, set overflow=1, quotient=all-ones, remainder=0.
  - Else: R=dividend[2W-1:W], Q=dividend[W-1:0], step counter=0, go to ITER.
- ITER, one step per cycle:
  - T = {R, Q[W-1]} (W+1 bits).
  - If T >= divisor: R = T - divisor and the new bit is 1; else R = T[W-1:0] and the new bit is 0.
  - Q = {Q[W-2:0], bit}.
  - After step W-1 (the counter has reached W-1), go to FIN.
- FIN: drive quotient=Q, remainder=R, done=1 for exactly this cycle, then return to IDLE.
- Invariant: R < divisor holds at every step, so R always fits in W bits. Only the compare/subtract is W+1 bits wide.
- Arithmetic is unsigned only. No rounding: quotient*divisor + remainder == dividend whenever neither flag is set.
- start asserted while busy or in FIN is ignored, and operand changes during the operation have no effect.
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, state=IDLE.
- rst during ITER or FIN aborts the operation immediately. No done pulse is produced and all outputs return to their reset values on the next edge.

## Timing
- The acceptance edge is cycle 0.
- Normal operation: ITER occupies cycles 1..W. FIN and the done pulse are in cycle W+1 (33 for W=32). busy=1 in cycles 1..W+1.
- Divide-by-zero and overflow: FIN is in cycle 1, so done and busy=1 last one cycle.
- Results and flags are registered. They change only in the FIN cycle or on reset.
- A new start is accepted in the cycle after FIN (IDLE). The back-to-back throughput is one operation per W+2 cycles.
- The critical path is the W+1-bit compare/subtract plus the mux. There is no combinational path from inputs to outputs.

## Structure
- Package `div_pkg` holds:
  - the state enum (IDLE/ITER/FIN);
  - `DIV_W = 32`;
  - the localparams for the all-ones quotient value and the counter width ($clog2(WIDTH)+1).
- Sub-module `div_restoring_step` is purely combinational. It takes inputs R, the next dividend bit and the divisor, and outputs the new R and the quotient bit. It is instantiated once.
- The top level contains the FSM, the operand registers, the step counter and the output registers.

## Test plan
- dividend=100, divisor=7, start pulsed at cycle 0 -> done only at cycle 33, quotient=14, remainder=2, both flags 0, busy high in cycles 1..33.
- dividend=0xFFFFFFFE_00000001, divisor=0xFFFFFFFF -> quotient=0xFFFFFFFF, remainder=0, done at cycle 33.
- divisor=0, dividend=0x12345678_9ABCDEF0 -> done at cycle 1, div_by_zero=1, quotient=0xFFFFFFFF, remainder=0x9ABCDEF0.
- dividend=0x00000001_00000000, divisor=1 -> done at cycle 1, overflow=1, quotient=0xFFFFFFFF, remainder=0. A following valid operation clears the flag.
- 1000/3 started; at cycle 10, start is pulsed with different operands -> ignored, result quotient=333, remainder=1 at cycle 33.
- 1000/3 started; rst asserted at cycle 15 -> all outputs 0, busy=0 on the next edge, no done pulse. A new 50/5 then returns quotient=10, remainder=0.

Source files
------------

// File: rtl/div_64by32_seq_pkg.sv
// Shared definitions for the sequential 2W-by-W restoring divider:
// FSM encoding, default width and derived constants.
package div_pkg;

    localparam int DIV_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ITER = ST_ITER,
        FIN  = ST_FIN
    } div_state_e;

    localparam logic [DIV_W-1:0] DIV_ALL_ONES = {DIV_W{1'b1}};

    // Counter must reach WIDTH-1; one spare bit keeps the compare simple.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/div_64by32_seq_if.sv
// Operand/result bundle of the divider; the master issues requests,
// the slave (divider) returns results.
interface div_64by32_seq_if #(
    parameter int WIDTH = 32
);
    // Handshake: start is sampled only while the divider is idle; one
    // request is accepted per such edge. done pulses for exactly one
    // cycle with quotient/remainder/flags valid, and they hold until the
    // next accepted start. busy covers acceptance+1 through done.
    logic               start;
    logic [2*WIDTH-1:0] dividend;
    logic [WIDTH-1:0]   divisor;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic               div_by_zero;
    logic               overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/div_restoring_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference if it did not go negative.
module div_restoring_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] r_next,
    output logic             q_bit
);
    logic [WIDTH:0] t;
    logic [WIDTH:0] diff;

    // r < divisor on entry, so t < 2*divisor and the result fits in WIDTH bits.
    always_comb begin
        t      = {r, next_bit};
        diff   = t - {1'b0, divisor};
        q_bit  = (t >= {1'b0, divisor});
        r_next = q_bit ? diff[WIDTH-1:0] : t[WIDTH-1:0];
    end
endmodule

// File: rtl/div_64by32_seq.sv
// Sequential unsigned 2W/W divider, one quotient bit per cycle behind a
// start/done handshake. Zero divisor and quotient overflow finish at once.
module div_64by32_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic                 clk,
    input  logic                 rst,
    div_64by32_seq_if.slave      bus,
    output logic [1:0]           state_dbg
);
    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] divisor_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] r_next;
    logic             q_bit;
    logic [WIDTH-1:0] q_next;

    div_restoring_step #(.WIDTH(WIDTH)) u_step (
        .r        (r_q),
        .next_bit (q_q[WIDTH-1]),
        .divisor  (divisor_q),
        .r_next   (r_next),
        .q_bit    (q_bit)
    );

    assign q_next    = {q_q[WIDTH-2:0], q_bit};
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            r_q             <= '0;
            q_q             <= '0;
            divisor_q       <= '0;
            cnt             <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        divisor_q <= bus.divisor;
                        r_q       <= bus.dividend[2*WIDTH-1:WIDTH];
                        q_q       <= bus.dividend[WIDTH-1:0];
                        cnt       <= '0;
                        bus.busy  <= 1'b1;
                        if (bus.divisor == '0) begin
                            state           <= ST_FIN;
                            bus.done        <= 1'b1;
                            bus.div_by_zero <= 1'b1;
                            bus.overflow    <= 1'b0;
                            bus.quotient    <= '1;
                            bus.remainder   <= bus.dividend[WIDTH-1:0];
                        end else if (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor) begin
                            state           <= ST_FIN;
                            bus.done        <= 1'b1;
                            bus.div_by_zero <= 1'b0;
                            bus.overflow    <= 1'b1;
                            bus.quotient    <= '1;
                            bus.remainder   <= '0;
                        end else begin
                            state <= ST_ITER;
                        end
                    end
                end
                ST_ITER: begin
                    r_q <= r_next;
                    q_q <= q_next;
                    cnt <= cnt + 1'b1;
                    // Results are registered on the way into FIN so done and data line up.
                    if (cnt == LAST_STEP) begin
                        state           <= ST_FIN;
                        bus.done        <= 1'b1;
                        bus.quotient    <= q_next;
                        bus.remainder   <= r_next;
                        bus.div_by_zero <= 1'b0;
                        bus.overflow    <= 1'b0;
                    end
                end
                ST_FIN: begin
                    state    <= ST_IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_64by32_seq.sv
// Directed bench for div_64by32_seq: timing of done/busy, results, flags,
// ignored restart and mid-operation reset abort.
module tb_div_64by32_seq;
    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;

    int n_checks;
    int n_fail;

    div_64by32_seq_if #(.WIDTH(32)) bus ();

    div_64by32_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation and follow it to done (or to a reset abort).
    // inject_cyc: cycle at which a second start with other operands is pulsed.
    // abort_cyc: cycle at which rst is raised; 0 disables either.
    task automatic run_op(input string tag, input logic [63:0] dvd, input logic [31:0] dvs,
                          input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input logic exp_dbz, input logic exp_ovf, input int exp_cyc,
                          input int inject_cyc, input int abort_cyc);
        int  cycle;
        bit  busy_ok;
        bit  done_seen;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = 64'hA5A5_5A5A_0F0F_F0F0;
        bus.divisor  = 32'h0000_0003;
        cycle   = 1;
        busy_ok = 1'b1;
        while (!bus.done && cycle < 60) begin
            if (!bus.busy) busy_ok = 1'b0;
            if (cycle == abort_cyc) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                check({tag, " abort flags"},
                      {60'd0, bus.busy, bus.done, bus.div_by_zero, bus.overflow}, 64'd0);
                check({tag, " abort quotient"}, {32'd0, bus.quotient}, 64'd0);
                check({tag, " abort remainder"}, {32'd0, bus.remainder}, 64'd0);
                check({tag, " abort state"}, {62'd0, state_dbg}, 64'd0);
                done_seen = 1'b0;
                for (int i = 0; i < 40; i++) begin
                    @(posedge clk);
                    #1;
                    if (bus.done) done_seen = 1'b1;
                end
                check({tag, " no done after abort"}, {63'd0, done_seen}, 64'd0);
                return;
            end
            if (cycle == inject_cyc) begin
                bus.start    = 1'b1;
                bus.dividend = 64'd77;
                bus.divisor  = 32'd5;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            cycle++;
        end
        bus.start = 1'b0;
        check({tag, " done cycle"}, 64'(cycle), 64'(exp_cyc));
        check({tag, " busy throughout"}, {63'd0, busy_ok & bus.busy}, 64'd1);
        check({tag, " quotient"}, {32'd0, bus.quotient}, {32'd0, exp_q});
        check({tag, " remainder"}, {32'd0, bus.remainder}, {32'd0, exp_r});
        check({tag, " flags"}, {62'd0, bus.div_by_zero, bus.overflow}, {62'd0, exp_dbz, exp_ovf});
        @(posedge clk);
        #1;
        check({tag, " done/busy drop"}, {62'd0, bus.done, bus.busy}, 64'd0);
        check({tag, " result held"}, {bus.quotient, bus.remainder}, {exp_q, exp_r});
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset flags", {60'd0, bus.busy, bus.done, bus.div_by_zero, bus.overflow}, 64'd0);
        check("reset results", {bus.quotient, bus.remainder}, 64'd0);
        check("reset state", {62'd0, state_dbg}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("100/7", 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33, 0, 0);
        run_op("max square", 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 33, 0, 0);
        run_op("low word/16", 64'h0000_0000_FFFF_FFFF, 32'h10,
               32'h0FFF_FFFF, 32'hF, 1'b0, 1'b0, 33, 0, 0);
        run_op("div by zero", 64'h1234_5678_9ABC_DEF0, 32'd0,
               32'hFFFF_FFFF, 32'h9ABC_DEF0, 1'b1, 1'b0, 1, 0, 0);
        run_op("overflow", 64'h0000_0001_0000_0000, 32'd1,
               32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1, 0, 0);
        run_op("after overflow", 64'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0, 33, 0, 0);
        run_op("ignored restart", 64'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0, 33, 10, 0);
        run_op("reset abort", 64'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 0, 0, 15);
        run_op("50/5", 64'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b0, 33, 0, 0);
        run_op("hi word nonzero", 64'h0000_0002_0000_0000, 32'd3,
               32'hAAAA_AAAA, 32'd2, 1'b0, 1'b0, 33, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
